player_motion_ctrl: RTL and testbench

- Player vertical-motion engine. Responds to the game-state FSM's `internal_reset` and `screen` outputs and to keyboard `keycode`.
- Produces player Y position, velocity and jump status for the ball/sprite drawing logic and the collision logic in the color mapper.
- Implements the jump/gravity sequence as a per-frame integrator. It replaces the fixed jump-state ladder.

---
 rtl/player_motion_ctrl.sv | 115 +++++++++++
 tb/tb_player_motion_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame jump/gravity integrator for the player's vertical motion
module player_motion_ctrl #(
    parameter int Y_W = 10,
    parameter int GROUND_Y = 400,
    parameter int JUMP_V0 = 12,
    parameter int GRAVITY = 1,
    parameter int MAX_FALL = 12,
    parameter logic [7:0] JUMP_KEY = 8'h1A,
    parameter int RESPAWN_FRAMES = 30
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              internal_reset,
    input  logic              screen,
    input  logic              frame_tick,
    input  logic [7:0]        keycode,
    output logic [Y_W-1:0]    player_y,
    output logic signed [5:0] player_vy,
    output logic              airborne,
    output logic              landed,
    output logic [7:0]        jump_count
);
    typedef enum logic [1:0] {IDLE, RESPAWN, GROUNDED, AIRBORNE} state_t;
    localparam int CW = $clog2(RESPAWN_FRAMES + 1);
    state_t state, state_n;
    logic [7:0] key_q, jc_n;
    logic jump_pending, press, jump_req, air_n, land_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [Y_W-1:0] y_n;
    logic signed [5:0] vy_n, vy_fall;
    logic signed [6:0] vy_inc;
    logic signed [Y_W+1:0] y_sum;
    assign press = (keycode == JUMP_KEY) && (key_q != JUMP_KEY);
    assign jump_req = jump_pending | press;
    assign y_sum = $signed({2'b00, player_y}) + (Y_W+2)'(player_vy);
    assign vy_inc = 7'(player_vy) + 7'(GRAVITY);
    assign vy_fall = (vy_inc > 7'(MAX_FALL)) ? 6'(MAX_FALL) : vy_inc[5:0];
    assign cnt_inc = cnt + 1'b1;
    always_comb begin
        state_n = state;
        y_n = player_y;
        vy_n = player_vy;
        air_n = airborne;
        land_n = 1'b0;
        jc_n = jump_count;
        cnt_n = cnt;
        if (internal_reset) begin
            state_n = RESPAWN;
            y_n = Y_W'(GROUND_Y);
            vy_n = '0;
            air_n = 1'b0;
            jc_n = '0;
            cnt_n = '0;
        end else if (!screen) begin
            state_n = IDLE;
            y_n = Y_W'(GROUND_Y);
            vy_n = '0;
            air_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: state_n = GROUNDED;
                RESPAWN: if (frame_tick) begin
                    cnt_n = cnt_inc;
                    state_n = (cnt_inc == CW'(RESPAWN_FRAMES)) ? GROUNDED : RESPAWN;
                end
                GROUNDED: if (frame_tick && jump_req) begin
                    state_n = AIRBORNE;
                    y_n = Y_W'(GROUND_Y - JUMP_V0);
                    vy_n = 6'(GRAVITY - JUMP_V0);
                    air_n = 1'b1;
                    jc_n = (jump_count == 8'hFF) ? jump_count : jump_count + 8'd1;
                end
                AIRBORNE: if (frame_tick) begin
                    if (y_sum >= (Y_W+2)'(GROUND_Y)) begin
                        state_n = GROUNDED;
                        y_n = Y_W'(GROUND_Y);
                        vy_n = '0;
                        air_n = 1'b0;
                        land_n = 1'b1;
                    end else if (y_sum[Y_W+1]) begin
                        y_n = '0;
                        vy_n = '0;
                    end else begin
                        y_n = y_sum[Y_W-1:0];
                        vy_n = vy_fall;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            player_y <= Y_W'(GROUND_Y);
            player_vy <= '0;
            airborne <= 1'b0;
            landed <= 1'b0;
            jump_count <= '0;
            cnt <= '0;
            key_q <= '0;
            jump_pending <= 1'b0;
        end else begin
            state <= state_n;
            player_y <= y_n;
            player_vy <= vy_n;
            airborne <= air_n;
            landed <= land_n;
            jump_count <= jc_n;
            cnt <= cnt_n;
            key_q <= keycode;
            jump_pending <= frame_tick ? 1'b0 : jump_pending | press;
        end
    end
endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: directed scenario checks of the player vertical-motion engine
module tb_player_motion_ctrl;
    logic Clk, Reset, internal_reset, screen, frame_tick;
    logic [7:0] keycode;
    logic [9:0] player_y;
    logic signed [5:0] player_vy;
    logic airborne, landed;
    logic [7:0] jump_count;
    int vectors = 0;
    int errors = 0;

    player_motion_ctrl dut (
        .Clk(Clk), .Reset(Reset), .internal_reset(internal_reset), .screen(screen),
        .frame_tick(frame_tick), .keycode(keycode), .player_y(player_y),
        .player_vy(player_vy), .airborne(airborne), .landed(landed), .jump_count(jump_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clocks(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic tick();
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press();
        @(negedge Clk) keycode = 8'h1A;
        @(negedge Clk) keycode = 8'h00;
    endtask

    task automatic do_reset(input logic scr);
        @(negedge Clk);
        Reset = 1'b1; internal_reset = 1'b0; frame_tick = 1'b0; keycode = 8'h00; screen = scr;
        clocks(2);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset = 1'b1; internal_reset = 1'b0; frame_tick = 1'b0; keycode = 8'h00; screen = 1'b0;
        clocks(2);
        vectors++;
        if (player_y !== 10'd400 || player_vy !== 6'sd0 || airborne !== 1'b0 || landed !== 1'b0 || jump_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: y=%0d vy=%0d air=%b land=%b jc=%0d, want 400 0 0 0 0", player_y, player_vy, airborne, landed, jump_count);
        end
        Reset = 1'b0;
    endtask

    task automatic test_grounded_idle();
        do_reset(1'b1);
        for (int t = 1; t <= 10; t++) begin
            tick();
            vectors++;
            if (player_y !== 10'd400 || player_vy !== 6'sd0 || airborne !== 1'b0) begin
                errors++;
                $display("FAIL grounded_tick%0d: y=%0d vy=%0d air=%b, want 400 0 0", t, player_y, player_vy, airborne);
            end
        end
    endtask

    task automatic test_jump_arc();
        do_reset(1'b1);
        clocks(2);
        press();
        tick();
        vectors++;
        if (player_y !== 10'd388 || player_vy !== -6'sd11 || airborne !== 1'b1 || jump_count !== 8'd1) begin
            errors++;
            $display("FAIL jump_tick1: y=%0d vy=%0d air=%b jc=%0d, want 388 -11 1 1", player_y, player_vy, airborne, jump_count);
        end
        clocks(5);
        vectors++;
        if (player_y !== 10'd388 || player_vy !== -6'sd11) begin
            errors++;
            $display("FAIL hold_between_ticks: y=%0d vy=%0d, want 388 -11", player_y, player_vy);
        end
        ticks(11);
        vectors++;
        if (player_y !== 10'd322 || player_vy !== 6'sd0 || airborne !== 1'b1) begin
            errors++;
            $display("FAIL jump_peak_tick12: y=%0d vy=%0d air=%b, want 322 0 1", player_y, player_vy, airborne);
        end
        ticks(12);
        vectors++;
        if (player_y !== 10'd388 || player_vy !== 6'sd12 || landed !== 1'b0) begin
            errors++;
            $display("FAIL jump_tick24: y=%0d vy=%0d land=%b, want 388 12 0", player_y, player_vy, landed);
        end
        press();
        tick();
        vectors++;
        if (player_y !== 10'd400 || player_vy !== 6'sd0 || airborne !== 1'b0 || landed !== 1'b1) begin
            errors++;
            $display("FAIL land_tick25: y=%0d vy=%0d air=%b land=%b, want 400 0 0 1", player_y, player_vy, airborne, landed);
        end
        clocks(1);
        vectors++;
        if (landed !== 1'b0) begin
            errors++;
            $display("FAIL landed_pulse_width: land=%b, want 0", landed);
        end
        tick();
        vectors++;
        if (airborne !== 1'b0 || jump_count !== 8'd1) begin
            errors++;
            $display("FAIL no_buffered_jump: air=%b jc=%0d, want 0 1", airborne, jump_count);
        end
    endtask

    task automatic test_hold_key();
        do_reset(1'b1);
        clocks(2);
        @(negedge Clk) begin keycode = 8'h1A; frame_tick = 1'b1; end
        @(negedge Clk) frame_tick = 1'b0;
        vectors++;
        if (airborne !== 1'b1 || jump_count !== 8'd1) begin
            errors++;
            $display("FAIL same_clk_press_tick: air=%b jc=%0d, want 1 1", airborne, jump_count);
        end
        ticks(59);
        vectors++;
        if (airborne !== 1'b0 || jump_count !== 8'd1 || player_y !== 10'd400) begin
            errors++;
            $display("FAIL held_key_one_jump: air=%b jc=%0d y=%0d, want 0 1 400", airborne, jump_count, player_y);
        end
        @(negedge Clk) keycode = 8'h00;
        press();
        tick();
        vectors++;
        if (airborne !== 1'b1 || jump_count !== 8'd2) begin
            errors++;
            $display("FAIL repress_jump: air=%b jc=%0d, want 1 2", airborne, jump_count);
        end
        ticks(24);
    endtask

    task automatic test_respawn();
        int jumped;
        do_reset(1'b1);
        clocks(2);
        press();
        ticks(8);
        vectors++;
        if (player_y !== 10'd332 || player_vy !== -6'sd4 || jump_count !== 8'd1) begin
            errors++;
            $display("FAIL midair_tick8: y=%0d vy=%0d jc=%0d, want 332 -4 1", player_y, player_vy, jump_count);
        end
        @(negedge Clk) internal_reset = 1'b1;
        @(negedge Clk) internal_reset = 1'b0;
        vectors++;
        if (player_y !== 10'd400 || player_vy !== 6'sd0 || jump_count !== 8'd0 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL respawn_entry: y=%0d vy=%0d jc=%0d air=%b, want 400 0 0 0", player_y, player_vy, jump_count, airborne);
        end
        jumped = 0;
        for (int t = 1; t <= 30; t++) begin
            press();
            tick();
            if (airborne !== 1'b0 || jump_count !== 8'd0) jumped++;
        end
        vectors++;
        if (jumped != 0) begin
            errors++;
            $display("FAIL respawn_ignore: %0d ticks jumped, want 0", jumped);
        end
        press();
        tick();
        vectors++;
        if (airborne !== 1'b1 || jump_count !== 8'd1 || player_y !== 10'd388) begin
            errors++;
            $display("FAIL respawn_tick31_jump: air=%b jc=%0d y=%0d, want 1 1 388", airborne, jump_count, player_y);
        end
        @(negedge Clk) internal_reset = 1'b1;
        ticks(3);
        @(negedge Clk) internal_reset = 1'b0;
        jumped = 0;
        for (int t = 1; t <= 30; t++) begin
            press();
            tick();
            if (airborne !== 1'b0) jumped++;
        end
        vectors++;
        if (jumped != 0) begin
            errors++;
            $display("FAIL respawn_held_counter: %0d ticks jumped, want 0", jumped);
        end
        press();
        tick();
        vectors++;
        if (airborne !== 1'b1) begin
            errors++;
            $display("FAIL respawn_held_release_jump: air=%b, want 1", airborne);
        end
    endtask

    task automatic test_screen_drop();
        do_reset(1'b1);
        clocks(2);
        press();
        ticks(3);
        @(negedge Clk) screen = 1'b0;
        @(negedge Clk);
        vectors++;
        if (player_y !== 10'd400 || player_vy !== 6'sd0 || airborne !== 1'b0 || jump_count !== 8'd1) begin
            errors++;
            $display("FAIL screen_drop: y=%0d vy=%0d air=%b jc=%0d, want 400 0 0 1", player_y, player_vy, airborne, jump_count);
        end
        press();
        tick();
        vectors++;
        if (airborne !== 1'b0 || jump_count !== 8'd1) begin
            errors++;
            $display("FAIL menu_ignores_key: air=%b jc=%0d, want 0 1", airborne, jump_count);
        end
        @(negedge Clk) begin screen = 1'b1; keycode = 8'h1A; end
        @(negedge Clk) begin keycode = 8'h00; frame_tick = 1'b1; end
        @(negedge Clk) frame_tick = 1'b0;
        vectors++;
        if (airborne !== 1'b1 || jump_count !== 8'd2) begin
            errors++;
            $display("FAIL screen_resume_jump: air=%b jc=%0d, want 1 2", airborne, jump_count);
        end
    endtask

    task automatic test_reset_collision();
        @(negedge Clk) begin Reset = 1'b1; internal_reset = 1'b1; frame_tick = 1'b1; keycode = 8'h1A; end
        @(negedge Clk) begin Reset = 1'b0; internal_reset = 1'b0; frame_tick = 1'b0; keycode = 8'h00; end
        vectors++;
        if (player_y !== 10'd400 || player_vy !== 6'sd0 || airborne !== 1'b0 || landed !== 1'b0 || jump_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_priority: y=%0d vy=%0d air=%b land=%b jc=%0d, want 400 0 0 0 0", player_y, player_vy, airborne, landed, jump_count);
        end
        press();
        tick();
        vectors++;
        if (airborne !== 1'b1 || jump_count !== 8'd1) begin
            errors++;
            $display("FAIL reset_not_respawn: air=%b jc=%0d, want 1 1", airborne, jump_count);
        end
    endtask

    initial begin
        Reset = 1'b1; internal_reset = 1'b0; screen = 1'b0; frame_tick = 1'b0; keycode = 8'h00;
        test_reset();
        test_grounded_idle();
        test_jump_arc();
        test_hold_key();
        test_respawn();
        test_screen_drop();
        test_reset_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
